// File: rtl/fpu_binary_to_bcd_param.sv
// Binary to packed-BCD converter (FBSTP-style) using multi-bit-per-cycle double-dabble.
// Overflow beyond BCD_DIGITS substitutes the 8087 packed-BCD indefinite encoding.
`timescale 1ns/1ps
module fpu_binary_to_bcd_param #(
  parameter int unsigned BIN_WIDTH      = 64,
  parameter int unsigned BCD_DIGITS     = 18,
  parameter int unsigned BITS_PER_CYCLE = 1,
  localparam int unsigned OUT_W         = 8 + 4 * BCD_DIGITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIN_WIDTH-1:0] binary_in,
  input  logic                 sign_in,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     bcd_out,
  output logic                 error
);

  localparam int unsigned Steps = BIN_WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CntW  = $clog2(Steps + 1);
  localparam int unsigned DigW  = 4 * BCD_DIGITS;
  localparam logic [OUT_W-1:0] IndefBase = OUT_W'(20'hFFFFC);
  localparam logic [OUT_W-1:0] Indef     = IndefBase << (OUT_W - 20);

  typedef enum logic [1:0] {StIdle, StConvert, StDone} state_e;

  state_e               state_q;
  logic [BIN_WIDTH-1:0] mag_q;
  logic [DigW-1:0]      digits_q;
  logic                 ovf_q;
  logic                 sign_q;
  logic [CntW-1:0]      cnt_q;

  logic [BIN_WIDTH-1:0] mag_d;
  logic [DigW-1:0]      digits_d;
  logic                 ovf_d;

  // BITS_PER_CYCLE chained add-3/shift iterations per clock.
  always_comb begin
    mag_d    = mag_q;
    digits_d = digits_q;
    ovf_d    = ovf_q;
    for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
      for (int k = 0; k < int'(BCD_DIGITS); k++) begin
        if (digits_d[4*k +: 4] >= 4'd5) begin
          digits_d[4*k +: 4] = digits_d[4*k +: 4] + 4'd3;
        end
      end
      ovf_d    = ovf_d | digits_d[DigW-1];
      digits_d = {digits_d[DigW-2:0], mag_d[BIN_WIDTH-1]};
      mag_d    = mag_d << 1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      mag_q     <= '0;
      digits_q  <= '0;
      ovf_q     <= 1'b0;
      sign_q    <= 1'b0;
      cnt_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      error     <= 1'b0;
      bcd_out   <= '0;
    end else if (flush) begin
      state_q   <= StIdle;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      error     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            if (signed_mode && binary_in[BIN_WIDTH-1]) begin
              mag_q  <= ~binary_in + BIN_WIDTH'(1);
              sign_q <= 1'b1;
            end else begin
              mag_q  <= binary_in;
              sign_q <= signed_mode ? 1'b0 : sign_in;
            end
            digits_q <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= CntW'(Steps);
            in_ready <= 1'b0;
            state_q  <= StConvert;
          end
        end
        StConvert: begin
          mag_q    <= mag_d;
          digits_q <= digits_d;
          ovf_q    <= ovf_d;
          cnt_q    <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            bcd_out   <= ovf_d ? Indef : {sign_q, 7'b0, digits_d};
            error     <= ovf_d;
            out_valid <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            error     <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
